lcv_div_iter: RTL and testbench
===============================

Name: lcv_div_iter

Overview:
- Iterative radix-2 restoring integer divider, signed or unsigned per request; the sequential inverse of the DSP48 multiply-accumulate blocks.
- Used by the CPU/ALU datapath for DIV/REM ops where a single-cycle divider is not affordable.
- One division in flight; valid/ready on both input and output sides.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- inp_valid  input  1  request valid
- inp_ready  output  1  block can accept a request
- inp_a  input  WIDTH  dividend
- inp_b  input  WIDTH  divisor
- inp_signed  input  1  1 = two's-complement operands, 0 = unsigned
- outp_valid  output  1  result valid
- outp_ready  input  1  consumer accepts result
- outp_quot  output  WIDTH  quotient
- outp_rem  output  WIDTH  remainder
- outp_div_by_zero  output  1  set when inp_b was 0

Behaviour:
- One clock `clk`, reset `rst` synchronous and active-high. Reset wins over all other inputs, including mid-operation.
- Reset values: state IDLE, outp_valid=0, outp_quot=0, outp_rem=0, outp_div_by_zero=0, iteration counter=0. inp_ready=1 the cycle after reset deasserts.
- States:
  - IDLE: inp_ready=1. Handshake (inp_valid & inp_ready) on edge E0 latches the operands.
    - Magnitudes are taken when inp_signed=1; result signs are recorded.
    - b==0: go to FIX with the div-by-zero flag set. Otherwise go to RUN with counter=0.
  - RUN: one restoring step per edge.
    - Shift {rem,quot} left 1 and bring in the next dividend bit MSB-first.
    - Trial-subtract |b| in WIDTH+1 bits; if non-negative, keep the difference and set quotient bit to 1.
    - After the WIDTH-th step (edge E_WIDTH), go to FIX.
  - FIX: apply sign fix-up and register the outputs.
    - Signed mode: quotient negated if the dividend and divisor signs differ; remainder takes the dividend's sign.
    - Unsigned mode: no change.
    - Goes to DONE on edge E_WIDTH+1.
  - DONE: outp_valid=1 and outputs held stable. On outp_valid & outp_ready, go to IDLE and deassert outp_valid. inp_ready=0 in RUN/FIX/DONE, so there is no accept in the same cycle as result handoff.
- Latency:
  - Normal: outp_valid high after edge WIDTH+1 counted from accept edge E0 (33 edges for WIDTH=32).
  - Div-by-zero: high after edge 1.
- Divide by zero: outp_quot = all ones, outp_rem = inp_a unmodified, outp_div_by_zero=1. Same in both modes.
- Signed overflow (MIN / -1): outp_quot = MIN, outp_rem = 0. This falls out naturally because the unsigned magnitude 2^(WIDTH-1) fits in WIDTH bits. No special case, no flag.
- Internal subtractor is WIDTH+1 bits so no carry is lost when |b| has its MSB set.
- Inputs are don't-care outside the accept cycle.

Optional Feature:
- Macro LCV_DIV_EARLY_OUT_EN.
- When defined: in IDLE, a non-zero-divisor request with |a| < |b| (unsigned comparison of magnitudes) skips RUN.
  - It goes directly to FIX with quotient 0 and remainder = inp_a (original sign preserved).
  - outp_valid is high after edge 1.
  - a==0 is included in this path.
- When undefined: every non-zero-divisor request takes the full WIDTH+1 latency.
- Results must be identical either way; only latency differs.

Test Plan (WIDTH=32):
- Unsigned 100/7, outp_ready=1 -> quot=14, rem=2, div_by_zero=0. outp_valid first high 33 edges after accept; inp_ready low throughout.
- Signed -7/2 (0xFFFFFFF9 / 0x2) -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1). Same operands unsigned -> quot=0x7FFFFFFC, rem=1.
- 5/0 in both modes -> quot=0xFFFFFFFF, rem=5, div_by_zero=1, outp_valid after 1 edge. Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
- Backpressure: 1000/10 with outp_ready held 0 for 10 cycles after outp_valid -> quot=100, rem=0 stable all 10 cycles, inp_ready=0. outp_ready=1 for one cycle -> next cycle outp_valid=0, inp_ready=1. Back-to-back request is accepted and correct.
- Reset mid-RUN: assert rst at iteration 10 of 123456/789 -> next cycle state IDLE, outp_valid=0, outputs 0. A new request 9/3 then yields quot=3, rem=0.
- Early-out (macro defined): 3/10 -> quot=0, rem=3, valid after 1 edge. With macro undefined, same values after 33 edges.

Source files
------------

// File: rtl/lcv_div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned), one division in flight.
// Optional macro LCV_DIV_EARLY_OUT_EN: skip iteration when |a| < |b|.
module lcv_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic             inp_signed,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [WIDTH-1:0] outp_quot,
  output logic [WIDTH-1:0] outp_rem,
  output logic             outp_div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bmag_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             early;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] fix_quot;
  logic [WIDTH-1:0] fix_rem;

  assign inp_ready = (state_q == S_IDLE);

  always_comb begin
    a_mag = (inp_signed && inp_a[WIDTH-1]) ? (~inp_a + 1'b1) : inp_a;
    b_mag = (inp_signed && inp_b[WIDTH-1]) ? (~inp_b + 1'b1) : inp_b;
  end

`ifdef LCV_DIV_EARLY_OUT_EN
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // Restoring step: the WIDTH+1-bit difference goes negative (MSB set) exactly
  // when the shifted partial remainder is smaller than |b|.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, bmag_q};
    rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quot_d  = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    fix_quot = '1;
    fix_rem  = a_q;
    if (!dz_q) begin
      fix_quot = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
      fix_rem  = neg_rem_q  ? (~rem_q + 1'b1)  : rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      a_q              <= '0;
      bmag_q           <= '0;
      rem_q            <= '0;
      quot_q           <= '0;
      neg_quot_q       <= 1'b0;
      neg_rem_q        <= 1'b0;
      dz_q             <= 1'b0;
      cnt_q            <= '0;
      outp_valid       <= 1'b0;
      outp_quot        <= '0;
      outp_rem         <= '0;
      outp_div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inp_valid) begin
            a_q        <= inp_a;
            bmag_q     <= b_mag;
            neg_quot_q <= inp_signed & (inp_a[WIDTH-1] ^ inp_b[WIDTH-1]);
            neg_rem_q  <= inp_signed & inp_a[WIDTH-1];
            dz_q       <= (inp_b == '0);
            cnt_q      <= '0;
            if (inp_b == '0) begin
              state_q <= S_FIX;
            end else if (early) begin
              // Quotient 0; remainder regains the dividend's sign in FIX.
              rem_q   <= a_mag;
              quot_q  <= '0;
              state_q <= S_FIX;
            end else begin
              rem_q   <= '0;
              quot_q  <= a_mag;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_q <= S_FIX;
        end
        S_FIX: begin
          outp_quot        <= fix_quot;
          outp_rem         <= fix_rem;
          outp_div_by_zero <= dz_q;
          outp_valid       <= 1'b1;
          state_q          <= S_DONE;
        end
        S_DONE: begin
          if (outp_ready) begin
            outp_valid <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcv_div_iter.sv
// Directed bench for lcv_div_iter (WIDTH=32) with hand-computed results.
module tb_lcv_div_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         inp_valid;
  logic         inp_ready;
  logic [W-1:0] inp_a;
  logic [W-1:0] inp_b;
  logic         inp_signed;
  logic         outp_valid;
  logic         outp_ready;
  logic [W-1:0] outp_quot;
  logic [W-1:0] outp_rem;
  logic         outp_div_by_zero;

  int checks = 0;
  int errors = 0;

`ifdef LCV_DIV_EARLY_OUT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif

  lcv_div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_a(inp_a), .inp_b(inp_b), .inp_signed(inp_signed),
    .outp_valid(outp_valid), .outp_ready(outp_ready),
    .outp_quot(outp_quot), .outp_rem(outp_rem),
    .outp_div_by_zero(outp_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it through to result handoff.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                         input logic exp_dz, input int exp_lat, input int hold);
    int  lat;
    bit  got;
    bit  ready_hi;
    @(negedge clk);
    chk({tag, ".ready_before"}, {31'b0, inp_ready}, 32'd1);
    inp_a = a; inp_b = b; inp_signed = sgn; inp_valid = 1'b1;
    outp_ready = (hold == 0);
    @(posedge clk);
    #1;
    inp_valid = 1'b0;
    inp_a = '1; inp_b = '1;
    lat = 0; got = 0; ready_hi = 0;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      if (inp_ready) ready_hi = 1;
      if (outp_valid) got = 1;
    end
    chk({tag, ".latency"}, W'(lat), W'(exp_lat));
    chk({tag, ".ready_low"}, {31'b0, ready_hi}, 32'd0);
    chk({tag, ".quot"}, outp_quot, exp_q);
    chk({tag, ".rem"}, outp_rem, exp_r);
    chk({tag, ".dz"}, {31'b0, outp_div_by_zero}, {31'b0, exp_dz});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, {31'b0, outp_valid}, 32'd1);
      chk({tag, ".hold_quot"}, outp_quot, exp_q);
      chk({tag, ".hold_rem"}, outp_rem, exp_r);
      chk({tag, ".hold_ready"}, {31'b0, inp_ready}, 32'd0);
    end
    outp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".valid_after"}, {31'b0, outp_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'b0, inp_ready}, 32'd1);
    $display("txn %s a=%h b=%h s=%0d -> q=%h r=%h dz=%0d lat=%0d", tag, a, b, sgn,
             exp_q, exp_r, exp_dz, lat);
  endtask

  initial begin
    rst = 1'b1; inp_valid = 1'b0; inp_a = '0; inp_b = '0; inp_signed = 1'b0; outp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.valid", {31'b0, outp_valid}, 32'd0);
    chk("reset.quot", outp_quot, 32'd0);
    chk("reset.rem", outp_rem, 32'd0);
    chk("reset.dz", {31'b0, outp_div_by_zero}, 32'd0);
    chk("reset.ready", {31'b0, inp_ready}, 32'd1);

    run_div("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        1'b0, 33, 0);
    run_div("s-7_2",    32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, 0);
    run_div("u-7_2",    32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC, 32'd1,        1'b0, 33, 0);
    run_div("s7_-2",    32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 33, 0);
    run_div("u5_0",     32'd5,          32'd0,          1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1,  0);
    run_div("s5_0",     32'd5,          32'd0,          1'b1, 32'hFFFFFFFF, 32'd5,        1'b1, 1,  0);
    run_div("s_min_-1", 32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        1'b0, 33, 0);
    run_div("u_ff_ff",  32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,        32'd0,        1'b0, 33, 0);
    run_div("u_fe_80",  32'hFFFFFFFE,   32'h80000000,   1'b0, 32'd1,        32'h7FFFFFFE, 1'b0, 33, 0);
    run_div("bp1000_10", 32'd1000,      32'd10,         1'b0, 32'd100,      32'd0,        1'b0, 33, 10);
    run_div("b2b7_3",   32'd7,          32'd3,          1'b0, 32'd2,        32'd1,        1'b0, 33, 0);

    // Reset during iteration 10 of 123456/789.
    @(negedge clk);
    inp_a = 32'd123456; inp_b = 32'd789; inp_signed = 1'b0; inp_valid = 1'b1;
    @(posedge clk);
    #1;
    inp_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst.valid", {31'b0, outp_valid}, 32'd0);
    chk("midrst.quot", outp_quot, 32'd0);
    chk("midrst.rem", outp_rem, 32'd0);
    chk("midrst.dz", {31'b0, outp_div_by_zero}, 32'd0);
    chk("midrst.ready", {31'b0, inp_ready}, 32'd1);
    $display("txn midrst a=%h b=%h aborted by reset", 32'd123456, 32'd789);

    run_div("u9_3",     32'd9,          32'd3,          1'b0, 32'd3,        32'd0,        1'b0, 33, 0);
    run_div("u3_10",    32'd3,          32'd10,         1'b0, 32'd0,        32'd3,        1'b0, LAT_SMALL, 0);
    run_div("s-3_10",   32'hFFFFFFFD,   32'd10,         1'b1, 32'd0,        32'hFFFFFFFD, 1'b0, LAT_SMALL, 0);
    run_div("u0_5",     32'd0,          32'd5,          1'b0, 32'd0,        32'd0,        1'b0, LAT_SMALL, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
